fp_mul_round_pack: RTL and testbench

Normalise, round and pack stage of the pipelined floating-point multiplier. It sits directly downstream of stage 3 and consumes its registered outputs: sign, raw product mantissa, exponent, overflow bit, special-case codes, and the shift type and value. It applies the requested mantissa shift, rounds to nearest-even and resolves IEEE-754 special cases. Its output is the packed DW-bit result with status flags, after a two-register internal pipeline.

---
 rtl/fp_mul_pkg.sv | 29 ++
 rtl/fp_mul_round_pack_if.sv | 49 ++++
 rtl/fp_sticky_shifter.sv | 43 ++++
 rtl/fp_mul_round_pack.sv | 182 ++++++++++++++++++
 tb/tb_fp_mul_round_pack.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fp_mul_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fp_mul_pkg
// Purpose  : Shared constants and width helpers for the FP multiplier stages.
// Revision : 1.0 - initial release
// ============================================================================
package fp_mul_pkg;

    // Operand class codes; 5..7 are decoded as NaN.
    localparam logic [2:0] SPE_ZERO   = 3'd0;
    localparam logic [2:0] SPE_DENORM = 3'd1;
    localparam logic [2:0] SPE_NORM   = 3'd2;
    localparam logic [2:0] SPE_INF    = 3'd3;
    localparam logic [2:0] SPE_NAN    = 3'd4;

    localparam logic [1:0] SH_RIGHT = 2'b00;
    localparam logic [1:0] SH_LEFT  = 2'b01;
    localparam logic [1:0] SH_NONE  = 2'b10;

    function automatic int shift_w(input int dw);
        return (dw <= 16) ? 5 : ((dw <= 32) ? 6 : 7);
    endfunction

    function automatic int mant_mul(input int mant);
        return 2 * (mant + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp_mul_round_pack_if.sv
`default_nettype none
// ============================================================================
// Module   : fp_mul_round_pack_if
// Purpose  : Stage-3 to round/pack bundle: operands in, packed result out.
// Revision : 1.0 - initial release
// ============================================================================
interface fp_mul_round_pack_if #(
    parameter int DW   = 16,
    parameter int EXP  = 4,
    parameter int MANT = 10
);
    localparam int MW = fp_mul_pkg::mant_mul(MANT);
    localparam int SW = fp_mul_pkg::shift_w(DW);

    logic          en;
    logic          valid_in;
    logic          sign_reg3;
    logic [MW-1:0] mant_out_reg3;
    logic [EXP-1:0] exp_reg3;
    logic          over_flow_reg3;
    logic [2:0]    spe_case_a_reg3;
    logic [2:0]    spe_case_b_reg3;
    logic [1:0]    mant_shift_type_reg3;
    logic [SW-1:0] mant_shift_value_reg3;
    logic [DW-1:0] result;
    logic          valid_out;
    logic          flag_overflow;
    logic          flag_underflow;
    logic          flag_invalid;
    logic          flag_inexact;

    modport master (
        output en, valid_in, sign_reg3, mant_out_reg3, exp_reg3, over_flow_reg3,
               spe_case_a_reg3, spe_case_b_reg3, mant_shift_type_reg3,
               mant_shift_value_reg3,
        input  result, valid_out, flag_overflow, flag_underflow, flag_invalid,
               flag_inexact
    );

    modport slave (
        input  en, valid_in, sign_reg3, mant_out_reg3, exp_reg3, over_flow_reg3,
               spe_case_a_reg3, spe_case_b_reg3, mant_shift_type_reg3,
               mant_shift_value_reg3,
        output result, valid_out, flag_overflow, flag_underflow, flag_invalid,
               flag_inexact
    );

endinterface
`default_nettype wire

// File: rtl/fp_sticky_shifter.sv
`default_nettype none
// ============================================================================
// Module   : fp_sticky_shifter
// Purpose  : Combinational left/right barrel shift; right shifts report sticky.
// Revision : 1.0 - initial release
// ============================================================================
module fp_sticky_shifter
    import fp_mul_pkg::*;
#(
    parameter int W  = 22,
    parameter int SW = 5
) (
    input  logic [W-1:0]  data_in,
    input  logic [1:0]    shift_type,
    input  logic [SW-1:0] shift_value,
    output logic [W-1:0]  data_out,
    output logic          sticky
);

    localparam logic [SW-1:0] MAX_RSH = SW'(W - 1);

    logic [SW-1:0]  w_rsh_amt;
    logic [2*W-1:0] w_rsh_ext;

    // Lower half of the extended word collects every bit shifted out.
    assign w_rsh_amt = (shift_value > MAX_RSH) ? MAX_RSH : shift_value;
    assign w_rsh_ext = {data_in, {W{1'b0}}} >> w_rsh_amt;

    always_comb begin
        data_out = data_in;
        sticky   = 1'b0;
        case (shift_type)
            SH_RIGHT: begin
                data_out = w_rsh_ext[2*W-1:W];
                sticky   = |w_rsh_ext[W-1:0];
            end
            SH_LEFT: data_out = data_in << shift_value;
            default: data_out = data_in;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/fp_mul_round_pack.sv
`default_nettype none
// ============================================================================
// Module   : fp_mul_round_pack
// Purpose  : Normalise/round-to-nearest-even/pack stage of the FP multiplier.
// Revision : 1.0 - initial release
// ============================================================================
module fp_mul_round_pack
    import fp_mul_pkg::*;
#(
    parameter int DW    = 16,
    parameter int EXP   = 4,
    parameter int MANT  = 10,
    parameter bit CG_EN = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    fp_mul_round_pack_if.slave bus
);

    localparam int MW = mant_mul(MANT);
    localparam int SW = shift_w(DW);
    localparam int EW = DW - 1 - MANT;
    localparam int RW = EW + MANT + 1;

    logic          w_adv;
    logic [MW-1:0] w_shifted;
    logic          w_sh_sticky;
    logic          w_lead_unused;
    logic [EW-1:0] w_exp_in;

    assign w_adv = CG_EN ? 1'b1 : bus.en;

    fp_sticky_shifter #(
        .W  (MW),
        .SW (SW)
    ) u_shifter (
        .data_in     (bus.mant_out_reg3),
        .shift_type  (bus.mant_shift_type_reg3),
        .shift_value (bus.mant_shift_value_reg3),
        .data_out    (w_shifted),
        .sticky      (w_sh_sticky)
    );

    // The leading one is implicit in the packed format.
    assign w_lead_unused = w_shifted[MW-1];

    generate
        if (EXP > EW) begin : g_exp_trunc
            logic w_exp_hi_unused;
            assign w_exp_hi_unused = ^bus.exp_reg3[EXP-1:EW];
            assign w_exp_in        = bus.exp_reg3[EW-1:0];
        end else if (EXP == EW) begin : g_exp_same
            assign w_exp_in = bus.exp_reg3;
        end else begin : g_exp_ext
            assign w_exp_in = {{(EW-EXP){1'b0}}, bus.exp_reg3};
        end
    endgenerate

    // ---------------- cycle A: shift and split fields ----------------
    logic            r_a_valid;
    logic            r_a_sign;
    logic [EW-1:0]   r_a_exp;
    logic [MANT-1:0] r_a_frac;
    logic            r_a_guard;
    logic            r_a_sticky;
    logic            r_a_ovf;
    logic [2:0]      r_a_spe_a;
    logic [2:0]      r_a_spe_b;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a_valid  <= 1'b0;
            r_a_sign   <= 1'b0;
            r_a_exp    <= '0;
            r_a_frac   <= '0;
            r_a_guard  <= 1'b0;
            r_a_sticky <= 1'b0;
            r_a_ovf    <= 1'b0;
            r_a_spe_a  <= '0;
            r_a_spe_b  <= '0;
        end else if (w_adv) begin
            r_a_valid  <= bus.valid_in;
            r_a_sign   <= bus.sign_reg3;
            r_a_exp    <= w_exp_in;
            r_a_frac   <= w_shifted[MW-2 -: MANT];
            r_a_guard  <= w_shifted[MW-2-MANT];
            r_a_sticky <= (|w_shifted[MW-3-MANT:0]) | w_sh_sticky;
            r_a_ovf    <= bus.over_flow_reg3;
            r_a_spe_a  <= bus.spe_case_a_reg3;
            r_a_spe_b  <= bus.spe_case_b_reg3;
        end
    end

    // ---------------- cycle B: round and resolve specials ----------------
    logic          w_round_up;
    logic [RW-1:0] w_sum;
    logic [EW-1:0] w_sum_exp;
    logic          w_post_ovf;
    logic          w_inexact;
    logic          w_nan_any;
    logic          w_inf_any;
    logic          w_zero_any;
    logic [DW-1:0] w_res;
    logic          w_f_ovf;
    logic          w_f_unf;
    logic          w_f_inv;
    logic          w_f_inx;

    // A fraction carry rolls into the exponent, covering both renormalisation
    // and denormal-to-normal promotion.
    assign w_round_up = r_a_guard & (r_a_sticky | r_a_frac[0]);
    assign w_sum      = {1'b0, r_a_exp, r_a_frac} + {{(RW-1){1'b0}}, w_round_up};
    assign w_sum_exp  = w_sum[RW-2:MANT];
    assign w_post_ovf = w_sum[RW-1] | (&w_sum_exp);
    assign w_inexact  = r_a_guard | r_a_sticky;

    assign w_nan_any  = (r_a_spe_a >= SPE_NAN) | (r_a_spe_b >= SPE_NAN);
    assign w_inf_any  = (r_a_spe_a == SPE_INF) | (r_a_spe_b == SPE_INF);
    assign w_zero_any = (r_a_spe_a == SPE_ZERO) | (r_a_spe_b == SPE_ZERO);

    always_comb begin
        w_res   = {r_a_sign, w_sum[RW-2:0]};
        w_f_ovf = 1'b0;
        w_f_unf = 1'b0;
        w_f_inv = 1'b0;
        w_f_inx = 1'b0;
        if (w_nan_any || (w_inf_any && w_zero_any)) begin
            w_res   = {1'b0, {EW{1'b1}}, 1'b1, {(MANT-1){1'b0}}};
            w_f_inv = 1'b1;
        end else if (w_inf_any) begin
            w_res = {r_a_sign, {EW{1'b1}}, {MANT{1'b0}}};
        end else if (w_zero_any) begin
            w_res = {r_a_sign, {(DW-1){1'b0}}};
        end else if (r_a_ovf) begin
            w_res   = {r_a_sign, {EW{1'b1}}, {MANT{1'b0}}};
            w_f_ovf = 1'b1;
            w_f_inx = 1'b1;
        end else begin
            w_f_inx = w_inexact;
            if (w_post_ovf) begin
                w_res   = {r_a_sign, {EW{1'b1}}, {MANT{1'b0}}};
                w_f_ovf = 1'b1;
            end else begin
                w_f_unf = (w_sum_exp == '0) & w_inexact;
            end
        end
    end

    logic          r_valid;
    logic [DW-1:0] r_result;
    logic          r_flag_ovf;
    logic          r_flag_unf;
    logic          r_flag_inv;
    logic          r_flag_inx;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid    <= 1'b0;
            r_result   <= '0;
            r_flag_ovf <= 1'b0;
            r_flag_unf <= 1'b0;
            r_flag_inv <= 1'b0;
            r_flag_inx <= 1'b0;
        end else if (w_adv) begin
            r_valid    <= r_a_valid;
            r_result   <= w_res;
            r_flag_ovf <= w_f_ovf & r_a_valid;
            r_flag_unf <= w_f_unf & r_a_valid;
            r_flag_inv <= w_f_inv & r_a_valid;
            r_flag_inx <= w_f_inx & r_a_valid;
        end
    end

    assign bus.valid_out      = r_valid;
    assign bus.result         = r_result;
    assign bus.flag_overflow  = r_flag_ovf;
    assign bus.flag_underflow = r_flag_unf;
    assign bus.flag_invalid   = r_flag_inv;
    assign bus.flag_inexact   = r_flag_inx;

endmodule
`default_nettype wire

// File: tb/tb_fp_mul_round_pack.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_mul_round_pack
// Purpose  : Directed-vector bench for the round/pack stage (DW=16, EXP=5).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_mul_round_pack;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    fp_mul_round_pack_if #(.DW(16), .EXP(5), .MANT(10)) bus ();

    fp_mul_round_pack #(
        .DW    (16),
        .EXP   (5),
        .MANT  (10),
        .CG_EN (1'b0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] flags();
        return {bus.flag_overflow, bus.flag_underflow, bus.flag_invalid, bus.flag_inexact};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic s, input logic [21:0] m, input logic [1:0] t,
                          input logic [4:0] v, input logic [4:0] e, input logic o,
                          input logic [2:0] ca, input logic [2:0] cb);
        bus.valid_in              = 1'b1;
        bus.sign_reg3             = s;
        bus.mant_out_reg3         = m;
        bus.mant_shift_type_reg3  = t;
        bus.mant_shift_value_reg3 = v;
        bus.exp_reg3              = e;
        bus.over_flow_reg3        = o;
        bus.spe_case_a_reg3       = ca;
        bus.spe_case_b_reg3       = cb;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.en = 1'b1;
        set_op(1'b0, 22'h100000, 2'b01, 5'd1, 5'd15, 1'b0, 3'd2, 3'd2);
        tick();
        bus.en = 1'b0;
        tick();
        checks++;
        if (bus.valid_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got %b want 0", bus.valid_out);
        end
        checks++;
        if (bus.result !== 16'h0000) begin
            errors++;
            $display("FAIL reset_result: got %h want 0000", bus.result);
        end
        checks++;
        if (flags() !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b want 0000", flags());
        end
        rst_n = 1'b1;
        bus.en = 1'b1;
        bus.valid_in = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_normal();
        set_op(1'b0, 22'h100000, 2'b01, 5'd1, 5'd15, 1'b0, 3'd2, 3'd2);
        tick();
        bus.valid_in = 1'b0;
        checks++;
        if (bus.valid_out !== 1'b0) begin
            errors++;
            $display("FAIL normal_latency: valid_out got %b want 0 after 1 cycle", bus.valid_out);
        end
        tick();
        checks++;
        if (bus.valid_out !== 1'b1 || bus.result !== 16'h3C00) begin
            errors++;
            $display("FAIL normal_result: got v=%b %h want v=1 3C00", bus.valid_out, bus.result);
        end
        checks++;
        if (flags() !== 4'b0000) begin
            errors++;
            $display("FAIL normal_flags: got %b want 0000", flags());
        end
        tick();
        checks++;
        if (bus.valid_out !== 1'b0 || flags() !== 4'b0000) begin
            errors++;
            $display("FAIL normal_drain: got v=%b flags=%b want v=0 flags=0000", bus.valid_out, flags());
        end
    endtask

    task automatic test_round_overflow();
        set_op(1'b0, 22'h3FFC00, 2'b10, 5'd0, 5'd30, 1'b0, 3'd2, 3'd2);
        tick();
        bus.valid_in = 1'b0;
        tick();
        checks++;
        if (bus.valid_out !== 1'b1 || bus.result !== 16'h7C00) begin
            errors++;
            $display("FAIL round_carry_result: got v=%b %h want v=1 7C00", bus.valid_out, bus.result);
        end
        checks++;
        if (flags() !== 4'b1001) begin
            errors++;
            $display("FAIL round_carry_flags: got %b want 1001", flags());
        end
        // Exact tie with even LSB must not round up: frac 0x002, guard 1, sticky 0.
        set_op(1'b1, 22'h201400, 2'b11, 5'd0, 5'd20, 1'b0, 3'd1, 3'd2);
        tick();
        bus.valid_in = 1'b0;
        tick();
        checks++;
        if (bus.result !== 16'hD002 || flags() !== 4'b0001) begin
            errors++;
            $display("FAIL round_tie_even: got %h flags=%b want D002 flags=0001", bus.result, flags());
        end
    endtask

    task automatic test_denorm_sticky();
        set_op(1'b0, 22'h200001, 2'b00, 5'd3, 5'd0, 1'b0, 3'd1, 3'd2);
        tick();
        bus.valid_in = 1'b0;
        tick();
        checks++;
        if (bus.valid_out !== 1'b1 || bus.result !== 16'h0080) begin
            errors++;
            $display("FAIL denorm_result: got v=%b %h want v=1 0080", bus.valid_out, bus.result);
        end
        checks++;
        if (flags() !== 4'b0101) begin
            errors++;
            $display("FAIL denorm_flags: got %b want 0101", flags());
        end
        // Right shift far beyond width saturates; everything but the MSB goes to sticky.
        set_op(1'b0, 22'h3FFFFF, 2'b00, 5'd31, 5'd0, 1'b0, 3'd1, 3'd1);
        tick();
        bus.valid_in = 1'b0;
        tick();
        checks++;
        if (bus.result !== 16'h0000 || flags() !== 4'b0101) begin
            errors++;
            $display("FAIL rshift_saturate: got %h flags=%b want 0000 flags=0101", bus.result, flags());
        end
    endtask

    task automatic test_special();
        logic        sg [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic        ov [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [2:0]  ca [5] = '{3'd4, 3'd3, 3'd3, 3'd0, 3'd2};
        logic [2:0]  cb [5] = '{3'd2, 3'd0, 3'd2, 3'd2, 3'd2};
        logic [15:0] er [5] = '{16'h7E00, 16'h7E00, 16'hFC00, 16'h8000, 16'h7C00};
        logic [3:0]  ef [5] = '{4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b1001};
        for (int i = 0; i < 5; i++) begin
            set_op(sg[i], 22'h100000, 2'b01, 5'd1, 5'd15, ov[i], ca[i], cb[i]);
            tick();
            bus.valid_in = 1'b0;
            tick();
            checks++;
            if (bus.result !== er[i]) begin
                errors++;
                $display("FAIL special_result[%0d]: got %h want %h", i, bus.result, er[i]);
            end
            checks++;
            if (flags() !== ef[i]) begin
                errors++;
                $display("FAIL special_flags[%0d]: got %b want %b", i, flags(), ef[i]);
            end
        end
    endtask

    task automatic test_stall();
        set_op(1'b0, 22'h100000, 2'b01, 5'd1, 5'd15, 1'b0, 3'd2, 3'd2);
        tick();
        set_op(1'b0, 22'h200001, 2'b00, 5'd3, 5'd0, 1'b0, 3'd1, 3'd2);
        tick();
        checks++;
        if (bus.valid_out !== 1'b1 || bus.result !== 16'h3C00) begin
            errors++;
            $display("FAIL stall_op1: got v=%b %h want v=1 3C00", bus.valid_out, bus.result);
        end
        bus.en = 1'b0;
        set_op(1'b0, 22'h000000, 2'b10, 5'd0, 5'd0, 1'b0, 3'd4, 3'd4);
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (bus.valid_out !== 1'b1 || bus.result !== 16'h3C00 || flags() !== 4'b0000) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got v=%b %h flags=%b want v=1 3C00 flags=0000",
                         i, bus.valid_out, bus.result, flags());
            end
        end
        bus.en = 1'b1;
        set_op(1'b1, 22'h100000, 2'b01, 5'd1, 5'd15, 1'b0, 3'd0, 3'd2);
        tick();
        bus.valid_in = 1'b0;
        checks++;
        if (bus.valid_out !== 1'b1 || bus.result !== 16'h0080 || flags() !== 4'b0101) begin
            errors++;
            $display("FAIL stall_op2: got v=%b %h flags=%b want v=1 0080 flags=0101",
                     bus.valid_out, bus.result, flags());
        end
        tick();
        checks++;
        if (bus.valid_out !== 1'b1 || bus.result !== 16'h8000 || flags() !== 4'b0000) begin
            errors++;
            $display("FAIL stall_op3: got v=%b %h flags=%b want v=1 8000 flags=0000",
                     bus.valid_out, bus.result, flags());
        end
        tick();
        checks++;
        if (bus.valid_out !== 1'b0) begin
            errors++;
            $display("FAIL stall_no_dup: valid_out got %b want 0", bus.valid_out);
        end
    endtask

    task automatic test_reset_midflight();
        set_op(1'b0, 22'h100000, 2'b01, 5'd1, 5'd15, 1'b0, 3'd2, 3'd2);
        tick();
        set_op(1'b0, 22'h000000, 2'b10, 5'd0, 5'd0, 1'b0, 3'd4, 3'd2);
        tick();
        bus.valid_in = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if (bus.valid_out !== 1'b0 || bus.result !== 16'h0000) begin
            errors++;
            $display("FAIL midreset_clear: got v=%b %h want v=0 0000", bus.valid_out, bus.result);
        end
        tick();
        checks++;
        if (bus.valid_out !== 1'b0) begin
            errors++;
            $display("FAIL midreset_discard: valid_out got %b want 0", bus.valid_out);
        end
        set_op(1'b1, 22'h100000, 2'b01, 5'd1, 5'd15, 1'b0, 3'd3, 3'd2);
        tick();
        bus.valid_in = 1'b0;
        checks++;
        if (bus.valid_out !== 1'b0) begin
            errors++;
            $display("FAIL midreset_early: valid_out got %b want 0", bus.valid_out);
        end
        tick();
        checks++;
        if (bus.valid_out !== 1'b1 || bus.result !== 16'hFC00 || flags() !== 4'b0000) begin
            errors++;
            $display("FAIL midreset_new_op: got v=%b %h flags=%b want v=1 FC00 flags=0000",
                     bus.valid_out, bus.result, flags());
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.en = 1'b1;
        bus.valid_in = 1'b0;
        bus.sign_reg3 = 1'b0;
        bus.mant_out_reg3 = '0;
        bus.mant_shift_type_reg3 = 2'b10;
        bus.mant_shift_value_reg3 = '0;
        bus.exp_reg3 = '0;
        bus.over_flow_reg3 = 1'b0;
        bus.spe_case_a_reg3 = 3'd2;
        bus.spe_case_b_reg3 = 3'd2;
        #2;
        test_reset();
        test_normal();
        test_round_overflow();
        test_denorm_sticky();
        test_special();
        test_stall();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
